// File: rtl/stbuf_ctrl.sv
// Store buffer between the load/store execute unit and the single dmem port.
// Executed stores queue in program order, become committed as the ROB retires
// them, and drain to dmem whenever the load path leaves the port free. The
// buffer also forwards store data to loads and blocks load issue when stores
// have been starved of the port for too long.
//
// Handshakes: a push is i_exfin_st (valid) with an implied ready of
// !o_stbuf_full, and the load/store unit never pushes into a full buffer. A
// drain is o_dmem_we (valid) with !i_dmem_occupy as ready; o_dmem_we already
// folds in the ready, so any cycle with o_dmem_we high is a completed
// transfer of the head entry.
module stbuf_ctrl #(
  parameter int STBUF_DEPTH = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_exfin_st,
  input  logic [ADDR_W-1:0] i_exfin_st_addr,
  input  logic [DATA_W-1:0] i_exfin_st_data,
  input  logic [1:0]        i_commit_st_num,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_ld_addr,
  output logic              o_stbuf_addr_hit,
  output logic [DATA_W-1:0] o_stbuf_rd_data,
  output logic              o_stbuf_full,
  output logic              o_stbuf_empty,
  input  logic              i_dmem_occupy,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  output logic              o_ld_block
);

  localparam int IW = $clog2(STBUF_DEPTH);
  localparam int PW = IW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] head_q, commit_q, tail_q;
  logic [PW-1:0] head_d, commit_d, tail_d;
  logic [PW-1:0] count, n_committed, n_uncommitted;
  logic [PW-1:0] commit_req, commit_adv;
  logic          push_ok;
  logic [SW-1:0] starve_q;
  logic [PW-1:0] fwd_ptr;

  logic [ADDR_W-1:0] addr_q [STBUF_DEPTH];
  logic [DATA_W-1:0] data_q [STBUF_DEPTH];

  assign count         = tail_q - head_q;
  assign n_committed   = commit_q - head_q;
  assign n_uncommitted = tail_q - commit_q;

  // Full/empty come from registered pointers only, never bypassed.
  assign o_stbuf_full  = (count == PW'(STBUF_DEPTH));
  assign o_stbuf_empty = (count == '0);

  // Loads always win the port; committed stores take it otherwise.
  assign o_dmem_we    = (n_committed != '0) && !i_dmem_occupy;
  assign o_dmem_addr  = addr_q[head_q[IW-1:0]];
  assign o_dmem_wdata = data_q[head_q[IW-1:0]];

  assign o_ld_block = (starve_q == SW'(STARVE_MAX));

  // A flush drops any store arriving in the same cycle.
  assign push_ok = i_exfin_st && !o_stbuf_full && !i_flush;

  // Next-pointer logic: commit is clamped to entries uncommitted at cycle
  // start, so a store pushed this cycle cannot be committed until the next.
  always_comb begin
    commit_req = PW'(i_commit_st_num);
    commit_adv = (commit_req > n_uncommitted) ? n_uncommitted : commit_req;
    head_d     = head_q + PW'(o_dmem_we);
    commit_d   = commit_q + commit_adv;
    tail_d     = i_flush ? commit_d : (tail_q + PW'(push_ok));
  end

  // Forwarding: walk valid entries oldest to youngest so the last match wins.
  always_comb begin
    o_stbuf_addr_hit = 1'b0;
    o_stbuf_rd_data  = '0;
    fwd_ptr          = head_q;
    for (int i = 0; i < STBUF_DEPTH; i++) begin
      fwd_ptr = head_q + PW'(i);
      if ((PW'(i) < count) && (addr_q[fwd_ptr[IW-1:0]] == i_ld_addr)) begin
        o_stbuf_addr_hit = 1'b1;
        o_stbuf_rd_data  = data_q[fwd_ptr[IW-1:0]];
      end
    end
  end

  // Pointer and starvation-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
      starve_q <= '0;
    end else begin
`ifndef SYNTHESIS
      assert (PW'(i_commit_st_num) <= n_uncommitted)
        else $error("stbuf_ctrl: commit of %0d exceeds %0d uncommitted stores",
                    i_commit_st_num, n_uncommitted);
`endif
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
      if ((n_committed != '0) && !o_dmem_we) begin
        if (starve_q != SW'(STARVE_MAX)) starve_q <= starve_q + 1'b1;
      end else begin
        starve_q <= '0;
      end
    end
  end

  // Entry storage, written at tail on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STBUF_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push_ok) begin
      addr_q[tail_q[IW-1:0]] <= i_exfin_st_addr;
      data_q[tail_q[IW-1:0]] <= i_exfin_st_data;
    end
  end

endmodule

// File: tb/tb_stbuf_ctrl.sv
// Self-checking bench for stbuf_ctrl: directed scenarios plus a randomized run
// against a queue-based model of the store buffer.
module tb_stbuf_ctrl;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SMAX   = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              ex_st;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_data;
  logic [1:0]        cnum;
  logic              flush;
  logic [ADDR_W-1:0] ld_addr;
  logic              occ;
  logic              hit, full, empty, we, blk;
  logic [DATA_W-1:0] rdata, wdata;
  logic [ADDR_W-1:0] waddr;

  stbuf_ctrl #(.STBUF_DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_exfin_st(ex_st), .i_exfin_st_addr(ex_addr), .i_exfin_st_data(ex_data),
    .i_commit_st_num(cnum), .i_flush(flush), .i_ld_addr(ld_addr),
    .o_stbuf_addr_hit(hit), .o_stbuf_rd_data(rdata),
    .o_stbuf_full(full), .o_stbuf_empty(empty),
    .i_dmem_occupy(occ), .o_dmem_we(we), .o_dmem_addr(waddr), .o_dmem_wdata(wdata),
    .o_ld_block(blk)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard / model: program-ordered stores {addr,data}; the first
  // m_ncommit are committed.
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int m_ncommit = 0;
  int m_starve  = 0;

  logic              e_we, e_full, e_empty, e_hit, e_blk;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_rdata;

  task automatic model_reset();
    exp_q.delete();
    m_ncommit = 0;
    m_starve  = 0;
  endtask

  // Expected outputs for the current inputs and model state.
  task automatic model_outputs();
    logic [ADDR_W+DATA_W-1:0] ent;
    e_we    = (m_ncommit > 0) && !occ;
    e_full  = (exp_q.size() == DEPTH);
    e_empty = (exp_q.size() == 0);
    e_blk   = (m_starve == SMAX);
    e_addr  = '0;
    e_wdata = '0;
    if (exp_q.size() > 0) begin
      ent = exp_q[0];
      e_addr  = ent[ADDR_W+DATA_W-1:DATA_W];
      e_wdata = ent[DATA_W-1:0];
    end
    e_hit   = 1'b0;
    e_rdata = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      ent = exp_q[i];
      if (ent[ADDR_W+DATA_W-1:DATA_W] == ld_addr) begin
        e_hit   = 1'b1;
        e_rdata = ent[DATA_W-1:0];
        break;
      end
    end
  endtask

  // State update at the clock edge from the inputs held during the cycle.
  task automatic model_tick();
    int  nc0, unc0, adv;
    bit  full0, dr;
    nc0   = m_ncommit;
    unc0  = exp_q.size() - nc0;
    adv   = (int'(cnum) < unc0) ? int'(cnum) : unc0;
    full0 = (exp_q.size() == DEPTH);
    dr    = (nc0 > 0) && !occ;
    if (nc0 > 0 && !dr) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
    else m_starve = 0;
    if (dr) begin
      void'(exp_q.pop_front());
      m_ncommit--;
    end
    m_ncommit += adv;
    if (flush) begin
      while (exp_q.size() > m_ncommit) void'(exp_q.pop_back());
    end else if (ex_st && !full0) begin
      exp_q.push_back({ex_addr, ex_data});
    end
  endtask

  // Driver tasks
  task automatic set_in(input bit st, input int a, input int d, input int cn,
                        input bit fl, input int ld, input bit oc);
    ex_st = st; ex_addr = ADDR_W'(a); ex_data = DATA_W'(d);
    cnum = 2'(cn); flush = fl; ld_addr = ADDR_W'(ld); occ = oc;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
    model_outputs();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic apply_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #3;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", we); end
    checks++; if (blk !== 1'b0) begin errors++; $display("FAIL reset_blk got %b exp 0", blk); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", hit); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    apply_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 'h100 + 4 * i, i + 1, 0, 0, 0, 0);
      mid_cycle();
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL fill_we[%0d] got %b exp 0", i, we); end
      end_cycle();
    end
    set_in(1, 'h500, 5, 0, 0, 0, 0);
    mid_cycle();
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    end_cycle();
    set_in(0, 0, 0, 0, 0, 'h500, 0);
    mid_cycle();
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL fill_ignored_push_hit got %b exp 0", hit); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_still_full got %b exp 1", full); end
    end_cycle();
  endtask

  task automatic test_drain();
    set_in(0, 0, 0, 2, 0, 0, 0);
    mid_cycle();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL drain_commit_we got %b exp 0", we); end
    end_cycle();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0);
      mid_cycle();
      checks++; if (we !== 1'b1) begin errors++; $display("FAIL drain_we[%0d] got %b exp 1", i, we); end
      checks++; if (waddr !== ADDR_W'('h100 + 4 * i)) begin errors++; $display("FAIL drain_addr[%0d] got %h exp %h", i, waddr, 'h100 + 4 * i); end
      checks++; if (wdata !== DATA_W'(i + 1)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, wdata, i + 1); end
      end_cycle();
    end
    mid_cycle();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL drain_done_we got %b exp 0", we); end
    checks++; if (full !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL drain_count2 full %b empty %b exp 0 0", full, empty); end
    end_cycle();
  endtask

  task automatic test_forward();
    set_in(1, 'h200, 'hAA, 0, 0, 0, 1); mid_cycle(); end_cycle();
    set_in(1, 'h200, 'hBB, 0, 0, 0, 1); mid_cycle(); end_cycle();
    set_in(0, 0, 0, 0, 0, 'h200, 1);
    mid_cycle();
    checks++; if (hit !== 1'b1 || rdata !== DATA_W'('hBB)) begin errors++; $display("FAIL fwd_young hit %b data %h exp 1 bb", hit, rdata); end
    end_cycle();
    set_in(0, 0, 0, 0, 0, 'h300, 1);
    mid_cycle();
    checks++; if (hit !== 1'b0 || rdata !== '0) begin errors++; $display("FAIL fwd_miss hit %b data %h exp 0 0", hit, rdata); end
    end_cycle();
    set_in(0, 0, 0, 0, 0, 'h108, 1);
    mid_cycle();
    checks++; if (hit !== 1'b1 || rdata !== DATA_W'(3)) begin errors++; $display("FAIL fwd_old hit %b data %h exp 1 3", hit, rdata); end
    end_cycle();
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 'h100 + 4 * i, i + 1, 0, 0, 0, 1); mid_cycle(); end_cycle();
    end
    set_in(0, 0, 0, 1, 0, 0, 1); mid_cycle(); end_cycle();
    set_in(1, 'h400, 9, 1, 1, 0, 1);
    mid_cycle();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL flush_we got %b exp 0", we); end
    end_cycle();
    set_in(0, 0, 0, 0, 0, 'h100, 0);
    mid_cycle();
    checks++; if (we !== 1'b1 || waddr !== ADDR_W'('h100)) begin errors++; $display("FAIL flush_drain0 we %b addr %h exp 1 100", we, waddr); end
    checks++; if (hit !== 1'b1 || rdata !== DATA_W'(1)) begin errors++; $display("FAIL flush_fwd_draining hit %b data %h exp 1 1", hit, rdata); end
    end_cycle();
    set_in(0, 0, 0, 0, 0, 'h108, 0);
    mid_cycle();
    checks++; if (we !== 1'b1 || waddr !== ADDR_W'('h104)) begin errors++; $display("FAIL flush_drain1 we %b addr %h exp 1 104", we, waddr); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_gone_hit got %b exp 0", hit); end
    end_cycle();
    set_in(0, 0, 0, 0, 0, 'h400, 0);
    mid_cycle();
    checks++; if (we !== 1'b0 || empty !== 1'b1 || hit !== 1'b0) begin errors++; $display("FAIL flush_end we %b empty %b hit %b exp 0 1 0", we, empty, hit); end
    end_cycle();
  endtask

  task automatic test_starve();
    apply_reset();
    set_in(1, 'h100, 1, 0, 0, 0, 1); mid_cycle(); end_cycle();
    set_in(0, 0, 0, 1, 0, 0, 1); mid_cycle(); end_cycle();
    for (int i = 0; i < SMAX; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1);
      mid_cycle();
      checks++; if (blk !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL starve_wait[%0d] blk %b we %b exp 0 0", i, blk, we); end
      end_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    mid_cycle();
    checks++; if (blk !== 1'b1 || we !== 1'b1) begin errors++; $display("FAIL starve_release blk %b we %b exp 1 1", blk, we); end
    end_cycle();
    mid_cycle();
    checks++; if (blk !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL starve_after blk %b empty %b exp 0 1", blk, empty); end
    end_cycle();
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 'h100 + 4 * i, i + 1, 0, 0, 0, 1); mid_cycle(); end_cycle();
    end
    set_in(0, 0, 0, 2, 0, 0, 1); mid_cycle(); end_cycle();
    set_in(0, 0, 0, 1, 0, 'h100, 0);
    mid_cycle();
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL rstmid_pre_we got %b exp 1", we); end
    rst_n = 1'b0;
    model_reset();
    set_in(0, 0, 0, 0, 0, 'h100, 0);
    #1;
    checks++; if (we !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rstmid_async we %b empty %b full %b exp 0 1 0", we, empty, full); end
    checks++; if (blk !== 1'b0 || hit !== 1'b0 || rdata !== '0) begin errors++; $display("FAIL rstmid_async2 blk %b hit %b data %h exp 0 0 0", blk, hit, rdata); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mid_cycle();
    checks++; if (empty !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL rstmid_after empty %b we %b exp 1 0", empty, we); end
    end_cycle();
  endtask

  task automatic test_random();
    int unc, cn;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      unc = exp_q.size() - m_ncommit;
      cn  = $urandom_range(0, 2);
      if (cn > unc) cn = unc;
      set_in(($urandom_range(0, 9) < 6), 'h100 + 4 * $urandom_range(0, 7),
             $urandom, cn, ($urandom_range(0, 19) == 0),
             'h100 + 4 * $urandom_range(0, 8), ($urandom_range(0, 9) < 4));
      mid_cycle();
      checks++;
      if (we !== e_we || full !== e_full || empty !== e_empty || blk !== e_blk ||
          hit !== e_hit || rdata !== e_rdata) begin
        errors++;
        $display("FAIL rnd_flags cyc %0d got we%b full%b empty%b blk%b hit%b data %h exp we%b full%b empty%b blk%b hit%b data %h",
                 c, we, full, empty, blk, hit, rdata, e_we, e_full, e_empty, e_blk, e_hit, e_rdata);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (waddr !== e_addr || wdata !== e_wdata) begin
          errors++;
          $display("FAIL rnd_head cyc %0d got %h/%h exp %h/%h", c, waddr, wdata, e_addr, e_wdata);
        end
      end
      end_cycle();
    end
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_forward();
    test_flush();
    test_starve();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stbuf_ctrl.md
Name: stbuf_ctrl

Overview:
- Store buffer and data-memory port scheduler behind the load/store execute unit.
- Executed stores are queued in program order and marked committed as the ROB retires them.
- Committed stores drain to the single dmem port whenever the load path is not using it.
- Also supplies store-to-load forwarding (address hit and data), the full signal back to the load/store unit, and an anti-starvation load block toward issue.

Parameters:
- STBUF_DEPTH, 4, number of entries; power of 2, at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive denied drain cycles before loads are blocked; at least 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_exfin_st  in  1  push one executed store.
- i_exfin_st_addr  in  ADDR_W  store address, word aligned.
- i_exfin_st_data  in  DATA_W  store data.
- i_commit_st_num  in  2  stores retired by the ROB this cycle (0..2).
- i_flush  in  1  mispredict flush; discards uncommitted entries.
- i_ld_addr  in  ADDR_W  load address for the forwarding search.
- o_stbuf_addr_hit  out  1  a valid entry matches i_ld_addr.
- o_stbuf_rd_data  out  DATA_W  data of the youngest matching entry; 0 when there is no hit.
- o_stbuf_full  out  1  count == STBUF_DEPTH.
- o_stbuf_empty  out  1  count == 0.
- i_dmem_occupy  in  1  load unit owns the dmem port this cycle.
- o_dmem_we  out  1  dmem write strobe for the head store.
- o_dmem_addr  out  ADDR_W  head entry address.
- o_dmem_wdata  out  DATA_W  head entry data.
- o_ld_block  out  1  issue must not dispatch loads this cycle.

Behaviour:
- Storage is a circular FIFO with head, commit and tail pointers, each log2(DEPTH)+1 bits; the MSB is the wrap bit.
- count = tail - head. Committed entries = commit - head. Uncommitted entries = tail - commit.
- Reset (asynchronous, any time, including mid-drain) clears all pointers, the valid state and the starve counter. Resulting outputs:
  - o_stbuf_empty = 1.
  - o_stbuf_full, o_dmem_we, o_ld_block, o_stbuf_addr_hit = 0.
  - o_stbuf_rd_data = 0.
- Push:
  - When i_exfin_st is high and the buffer is not full, write the entry at tail and advance tail by 1.
  - A push while full is ignored; the load/store unit never issues one.
- Commit:
  - Advance the commit pointer by i_commit_st_num.
  - The advance is clamped to the number of uncommitted entries present at the start of the cycle; the sim assertion fires on overflow.
  - A store pushed in the same cycle is not committable until the next cycle.
- Drain:
  - o_dmem_we = (committed entries > 0) && !i_dmem_occupy. This is combinational; loads always win the port.
  - o_dmem_addr and o_dmem_wdata always show the head entry.
  - When o_dmem_we is high, head advances by 1 at the edge.
  - Push, commit and drain may all happen in the same cycle and combine independently.
- Flush:
  - When i_flush is high, tail is set to the commit pointer, adjusted for any commit in the same cycle. Draining and committed entries survive.
  - A push in the same cycle as a flush is dropped.
- Forwarding (combinational):
  - Compare i_ld_addr against every valid entry, both committed and uncommitted.
  - The hit selects the youngest entry, i.e. the one closest to tail, including wrap-around ordering.
  - An entry draining this cycle still forwards.
  - Full-word match only.
- Starvation:
  - starve_cnt increments, saturating at STARVE_MAX, on each cycle where committed entries > 0 and o_dmem_we = 0.
  - It clears on any drain, or when no committed entries remain.
  - o_ld_block = (starve_cnt == STARVE_MAX), a registered-state decode. Once blocked, the next cycle with i_dmem_occupy = 0 drains and releases the block.
- Full and empty are decoded from the registered pointers only; they are not bypassed by same-cycle push or drain.

Test Plan:
- Reset then push 4 stores (A0..A3 = 0x100, 0x104, 0x108, 0x10C; data 1..4), no commit -> o_stbuf_full = 1; o_dmem_we stays 0; a 5th push is ignored.
- Commit 2 with i_dmem_occupy = 0 -> o_dmem_we high for 2 cycles with addr 0x100 then 0x104; count goes 4 -> 2.
- Push 0x200/0xAA then 0x200/0xBB, set i_ld_addr = 0x200 -> hit = 1, rd_data = 0xBB. With i_ld_addr = 0x300 -> hit = 0, data = 0.
- 3 entries, 1 committed, assert i_flush together with commit 1 -> 2 entries remain, both committed; tail == commit; both drain.
- One committed entry, i_dmem_occupy held at 1 -> o_ld_block rises after 4 denied cycles. Drop occupy -> drain happens the same cycle and o_ld_block falls the next cycle.
- Assert rst_n low during a drain with 3 entries -> all outputs go to reset values immediately; after release, o_stbuf_empty = 1.
